// File: rtl/xc_malu_long_seq.sv
// Sequencer and state holder for the multi-precision long-arithmetic datapath
// (madd/msub/macc/mmul). Accepts one request from decode, steps the
// combinational long datapath through one-hot fsm_* strobes, owns the
// acc/carry/count registers and signals completion with ready.
//
// Optional build macro: XC_MALU_LONG_SEQ_EARLY_OUT_EN
//   When defined, the mmul shift-add loop exits as soon as the remaining
//   multiplier bits of rs2 are all zero. When undefined, rs2 is unused and
//   the loop always runs MUL_STEPS cycles.
module xc_malu_long_seq #(
  parameter int MUL_STEPS = 32
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        valid,
  input  logic        flush,
  input  logic        uop_madd,
  input  logic        uop_msub,
  input  logic        uop_macc,
  input  logic        uop_mmul,
  input  logic [31:0] rs2,
  input  logic [63:0] dp_n_acc,
  input  logic        dp_n_carry,
  input  logic        dp_ready,
  input  logic [63:0] mdr_n_acc,
  output logic        fsm_init,
  output logic        fsm_mdr,
  output logic        fsm_msub_1,
  output logic        fsm_macc_1,
  output logic        fsm_mmul_1,
  output logic        fsm_mmul_2,
  output logic        fsm_done,
  output logic [63:0] acc,
  output logic        carry,
  output logic [5:0]  count,
  output logic        ready
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    MDR,
    MSUB_1,
    MACC_1,
    MMUL_2,
    MMUL_1,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] acc_d;
  logic        carry_d;
  logic [5:0]  count_d;
  logic        op_legal;
  logic        mdr_last;

  // A request is accepted only with exactly one op select bit set.
  assign op_legal = valid && $onehot({uop_madd, uop_msub, uop_macc, uop_mmul});

`ifdef XC_MALU_LONG_SEQ_EARLY_OUT_EN
  logic [6:0] next_step;

  // Leave MDR once no multiplier bits remain above the step just taken.
  assign next_step = {1'b0, count} + 7'd1;
  assign mdr_last  = (count == 6'(MUL_STEPS - 1)) || ((rs2 >> next_step) == 32'd0);
`else
  logic unused_rs2;

  // Fixed-length multiply loop; rs2 only matters for the early-out build.
  assign mdr_last   = (count == 6'(MUL_STEPS - 1));
  assign unused_rs2 = ^rs2;
`endif

  // Next-state, register next values, step strobes and ready.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    acc_d      = acc;
    carry_d    = carry;
    count_d    = count;
    ready      = 1'b0;
    fsm_init   = 1'b0;
    fsm_mdr    = 1'b0;
    fsm_msub_1 = 1'b0;
    fsm_macc_1 = 1'b0;
    fsm_mmul_1 = 1'b0;
    fsm_mmul_2 = 1'b0;
    fsm_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (op_legal) state_d = INIT;
      end
      INIT: begin
        fsm_init = 1'b1;
        if (uop_madd) begin
          if (dp_ready) begin
            ready   = 1'b1;
            acc_d   = dp_n_acc;
            state_d = IDLE;
          end
        end else if (uop_msub) begin
          acc_d   = dp_n_acc;
          carry_d = dp_n_carry;
          state_d = MSUB_1;
        end else if (uop_macc) begin
          acc_d   = dp_n_acc;
          carry_d = dp_n_carry;
          state_d = MACC_1;
        end else begin
          count_d = 6'd0;
          state_d = MDR;
        end
      end
      MDR: begin
        fsm_mdr = 1'b1;
        acc_d   = mdr_n_acc;
        count_d = count + 6'd1;
        if (mdr_last) state_d = MMUL_2;
      end
      MSUB_1: begin
        fsm_msub_1 = 1'b1;
        acc_d      = dp_n_acc;
        state_d    = DONE;
      end
      MACC_1: begin
        fsm_macc_1 = 1'b1;
        acc_d      = dp_n_acc;
        state_d    = DONE;
      end
      MMUL_2: begin
        fsm_mmul_2 = 1'b1;
        acc_d      = dp_n_acc;
        carry_d    = dp_n_carry;
        state_d    = MMUL_1;
      end
      MMUL_1: begin
        fsm_mmul_1 = 1'b1;
        acc_d      = dp_n_acc;
        state_d    = DONE;
      end
      DONE: begin
        fsm_done = 1'b1;
        ready    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides everything: back to IDLE with state registers frozen.
    if (flush) begin
      state_d = IDLE;
      ready   = 1'b0;
      acc_d   = acc;
      carry_d = carry;
      count_d = count;
    end
  end

  // State and datapath-feedback registers.
  always_ff @(posedge g_clk or posedge g_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (g_reset) begin
      state_q <= IDLE;
      acc     <= 64'd0;
      carry   <= 1'b0;
      count   <= 6'd0;
    end else begin
      state_q <= state_d;
      acc     <= acc_d;
      carry   <= carry_d;
      count   <= count_d;
    end
  end

endmodule

// File: tb/tb_xc_malu_long_seq.sv
// Self-checking bench for xc_malu_long_seq: directed op sequences with a
// per-cycle strobe model and a scoreboard of expected completion results.
module tb_xc_malu_long_seq;

  localparam int MUL_STEPS = 32;

  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_INIT  = 7'b1000000;
  localparam logic [6:0] S_MDR   = 7'b0100000;
  localparam logic [6:0] S_MSUB  = 7'b0010000;
  localparam logic [6:0] S_MACC  = 7'b0001000;
  localparam logic [6:0] S_MMUL1 = 7'b0000100;
  localparam logic [6:0] S_MMUL2 = 7'b0000010;
  localparam logic [6:0] S_DONE  = 7'b0000001;

  typedef enum int {OP_MADD, OP_MSUB, OP_MACC, OP_MMUL} op_e;

  typedef struct {
    string       tag;
    int          lat;
    logic [63:0] acc;
    logic        carry;
  } item_t;

  logic        g_clk;
  logic        g_reset;
  logic        valid;
  logic        flush;
  logic        uop_madd;
  logic        uop_msub;
  logic        uop_macc;
  logic        uop_mmul;
  logic [31:0] rs2;
  logic [63:0] dp_n_acc;
  logic        dp_n_carry;
  logic        dp_ready;
  logic [63:0] mdr_n_acc;
  logic        fsm_init;
  logic        fsm_mdr;
  logic        fsm_msub_1;
  logic        fsm_macc_1;
  logic        fsm_mmul_1;
  logic        fsm_mmul_2;
  logic        fsm_done;
  logic [63:0] acc;
  logic        carry;
  logic [5:0]  count;
  logic        ready;
  logic [6:0]  strobes;

  int          n_assert;
  int          n_fail;
  item_t       sb_q[$];
  logic [63:0] model_acc;
  logic        model_carry;

  xc_malu_long_seq #(.MUL_STEPS(MUL_STEPS)) dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .valid      (valid),
    .flush      (flush),
    .uop_madd   (uop_madd),
    .uop_msub   (uop_msub),
    .uop_macc   (uop_macc),
    .uop_mmul   (uop_mmul),
    .rs2        (rs2),
    .dp_n_acc   (dp_n_acc),
    .dp_n_carry (dp_n_carry),
    .dp_ready   (dp_ready),
    .mdr_n_acc  (mdr_n_acc),
    .fsm_init   (fsm_init),
    .fsm_mdr    (fsm_mdr),
    .fsm_msub_1 (fsm_msub_1),
    .fsm_macc_1 (fsm_macc_1),
    .fsm_mmul_1 (fsm_mmul_1),
    .fsm_mmul_2 (fsm_mmul_2),
    .fsm_done   (fsm_done),
    .acc        (acc),
    .carry      (carry),
    .count      (count),
    .ready      (ready)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Stand-in multiply-step unit: each MDR step adds 3 to the accumulator.
  assign mdr_n_acc = acc + 64'd3;
  assign strobes   = {fsm_init, fsm_mdr, fsm_msub_1, fsm_macc_1,
                      fsm_mmul_1, fsm_mmul_2, fsm_done};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_uops(input op_e op);
    uop_madd = (op == OP_MADD);
    uop_msub = (op == OP_MSUB);
    uop_macc = (op == OP_MACC);
    uop_mmul = (op == OP_MMUL);
  endtask

  function automatic int mdr_steps(input logic [31:0] r2);
    int hb;
`ifdef XC_MALU_LONG_SEQ_EARLY_OUT_EN
    hb = 0;
    for (int b = 31; b >= 0; b--) begin
      if (r2[b]) begin
        hb = b;
        break;
      end
    end
    return (hb + 1 > MUL_STEPS) ? MUL_STEPS : hb + 1;
`else
    hb = int'(r2 == 32'd0);
    return MUL_STEPS + hb - hb;
`endif
  endfunction

  // Expected one-hot strobe for cycle k (k=1 is the INIT cycle).
  function automatic logic [6:0] exp_strobe(input op_e op, input int k, input int mdr_len);
    if (k == 1 || op == OP_MADD) return S_INIT;
    case (op)
      OP_MSUB: return (k == 2) ? S_MSUB : S_DONE;
      OP_MACC: return (k == 2) ? S_MACC : S_DONE;
      default: begin
        if (k <= mdr_len + 1) return S_MDR;
        if (k == mdr_len + 2) return S_MMUL2;
        if (k == mdr_len + 3) return S_MMUL1;
        return S_DONE;
      end
    endcase
  endfunction

  // Issue one op; dp_n_acc = base - k and dp_n_carry = k[0] in cycle k.
  // stall delays dp_ready for madd; flush_k > 0 flushes in that cycle.
  task automatic run_op(input string tag, input op_e op, input logic [31:0] r2,
                        input logic [63:0] base, input int stall, input int flush_k);
    int          mdr_len;
    int          total;
    item_t       it;
    item_t       got;
    logic [63:0] acc0;
    logic [63:0] fin_acc;
    logic        fin_carry;
    mdr_len = (op == OP_MMUL) ? mdr_steps(r2) : 0;
    case (op)
      OP_MADD: total = 1 + stall;
      OP_MSUB, OP_MACC: total = 3;
      default: total = mdr_len + 4;
    endcase
    acc0 = model_acc;
    case (op)
      OP_MADD: begin fin_acc = base - 64'(total); fin_carry = model_carry; end
      OP_MSUB, OP_MACC: begin fin_acc = base - 64'd2; fin_carry = 1'b1; end
      default: begin
        fin_acc   = base - 64'(mdr_len + 3);
        fin_carry = 1'((mdr_len + 2) % 2);
      end
    endcase
    if (flush_k > 0) begin
      // Flush lands in MACC_1 in this bench: only the INIT update survives.
      fin_acc   = base - 64'd1;
      fin_carry = 1'b1;
    end else begin
      it.tag = tag; it.lat = total; it.acc = fin_acc; it.carry = fin_carry;
      sb_q.push_back(it);
    end

    valid = 1'b1;
    set_uops(op);
    rs2 = r2;
    #1;
    check({tag, " idle strobes"}, 64'(strobes), 64'(S_NONE));
    @(posedge g_clk); #1;
    for (int k = 1; k <= total; k++) begin
      dp_n_acc   = base - 64'(k);
      dp_n_carry = 1'(k % 2);
      dp_ready   = (k > stall);
      flush      = (k == flush_k);
      #1;
      check($sformatf("%s strobes k=%0d", tag, k), 64'(strobes), 64'(exp_strobe(op, k, mdr_len)));
      check($sformatf("%s ready k=%0d", tag, k), 64'(ready), 64'(k == total && k != flush_k));
      if (op == OP_MMUL && k >= 2 && k <= mdr_len + 1)
        check($sformatf("%s count k=%0d", tag, k), 64'(count), 64'(k - 2));
      if (op == OP_MMUL && k == mdr_len + 2)
        check({tag, " acc after mdr"}, acc, acc0 + 64'(3 * mdr_len));
      if (ready === 1'b1) begin
        check({tag, " scoreboard nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          got = sb_q.pop_front();
          check({got.tag, " latency"}, 64'(k), 64'(got.lat));
          fin_acc   = got.acc;
          fin_carry = got.carry;
        end
      end
      @(posedge g_clk); #1;
      if (k == flush_k) break;
    end
    valid = 1'b0;
    flush = 1'b0;
    dp_ready = 1'b0;
    uop_madd = 1'b0; uop_msub = 1'b0; uop_macc = 1'b0; uop_mmul = 1'b0;
    #1;
    check({tag, " back to idle"}, 64'(strobes), 64'(S_NONE));
    check({tag, " ready low after"}, 64'(ready), 64'd0);
    check({tag, " final acc"}, acc, fin_acc);
    check({tag, " final carry"}, 64'(carry), 64'(fin_carry));
    model_acc   = fin_acc;
    model_carry = fin_carry;
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    model_acc = 64'd0;
    model_carry = 1'b0;
    g_reset = 1'b1;
    valid = 1'b0; flush = 1'b0;
    uop_madd = 1'b0; uop_msub = 1'b0; uop_macc = 1'b0; uop_mmul = 1'b0;
    rs2 = 32'd0; dp_n_acc = 64'd0; dp_n_carry = 1'b0; dp_ready = 1'b0;

    #3;
    check("reset strobes", 64'(strobes), 64'(S_NONE));
    check("reset acc", acc, 64'd0);
    check("reset carry", 64'(carry), 64'd0);
    check("reset count", 64'(count), 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    @(negedge g_clk) g_reset = 1'b0;
    @(posedge g_clk); #1;

    run_op("madd", OP_MADD, 32'd0, 64'h1_0000_0004, 0, 0);
    run_op("madd_stall", OP_MADD, 32'd0, 64'h55, 2, 0);
    run_op("msub", OP_MSUB, 32'd0, 64'd6, 0, 0);
    run_op("macc", OP_MACC, 32'd0, 64'hABCD_0000_0000_0010, 0, 0);
    run_op("mmul_full", OP_MMUL, 32'hFFFF_FFFF, 64'h1000, 0, 0);
`ifdef XC_MALU_LONG_SEQ_EARLY_OUT_EN
    run_op("mmul_rs2_5", OP_MMUL, 32'h5, 64'h2000, 0, 0);
    run_op("mmul_rs2_0", OP_MMUL, 32'h0, 64'h3000, 0, 0);
`endif

    // Illegal op selects: two bits, then none; must stay in IDLE.
    valid = 1'b1;
    uop_madd = 1'b1; uop_mmul = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge g_clk); #1;
      check($sformatf("two_uops strobes c=%0d", c), 64'(strobes), 64'(S_NONE));
      check($sformatf("two_uops ready c=%0d", c), 64'(ready), 64'd0);
    end
    uop_madd = 1'b0; uop_mmul = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge g_clk); #1;
      check($sformatf("no_uop strobes c=%0d", c), 64'(strobes), 64'(S_NONE));
      check($sformatf("no_uop ready c=%0d", c), 64'(ready), 64'd0);
    end
    valid = 1'b0;
    @(posedge g_clk); #1;

    // Flush in MACC_1, then a madd accepted right away.
    run_op("macc_flush", OP_MACC, 32'd0, 64'h7777, 0, 2);
    run_op("madd_after_flush", OP_MADD, 32'd0, 64'h99, 0, 0);

    // Reset asserted mid-MDR at count=10, checked without a clock edge.
    valid = 1'b1;
    set_uops(OP_MMUL);
    rs2 = 32'hFFFF_FFFF;
    repeat (12) @(posedge g_clk);
    #1;
    check("pre-reset strobes", 64'(strobes), 64'(S_MDR));
    check("pre-reset count", 64'(count), 64'd10);
    g_reset = 1'b1;
    #1;
    check("midrun reset strobes", 64'(strobes), 64'(S_NONE));
    check("midrun reset acc", acc, 64'd0);
    check("midrun reset count", 64'(count), 64'd0);
    check("midrun reset carry", 64'(carry), 64'd0);
    check("midrun reset ready", 64'(ready), 64'd0);
    valid = 1'b0;
    uop_mmul = 1'b0;
    model_acc = 64'd0;
    model_carry = 1'b0;
    @(negedge g_clk) g_reset = 1'b0;
    @(posedge g_clk); #1;

    run_op("madd_post_reset", OP_MADD, 32'd0, 64'hDEAD_BEEF_0000_0001, 0, 0);

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
